// File: rtl/dds_voice_engine.sv
// Multi-voice DDS tone generator: voices are time-multiplexed four cycles each per
// frame, each with a gated linear envelope, mixed into a saturating valid/ready output.
module dds_voice_engine #(
    parameter int NUM_VOICES   = 4,
    parameter int PHASE_WIDTH  = 20,
    parameter int FRAME_CYCLES = 1024
) (
    input  logic                          clk_in,
    input  logic                          reset_n_in,
    input  logic                          wr_en_in,
    input  logic [$clog2(NUM_VOICES)+2:0] wr_addr_in,
    input  logic [15:0]                   wr_data_in,
    output logic [15:0]                   sample_out,
    output logic                          sample_valid_out,
    input  logic                          sample_ready_in,
    output logic                          overrun_out
);
    localparam int VA = $clog2(NUM_VOICES);
    localparam int CW = $clog2(FRAME_CYCLES);
    localparam int AW = 16 + VA;
    localparam int SW = PHASE_WIDTH - 16;
    localparam logic [CW-1:0] LOAD_CYCLE = CW'(4 * NUM_VOICES);
    localparam logic [CW-1:0] LAST_CYCLE = CW'(FRAME_CYCLES - 1);

    logic [PHASE_WIDTH-1:0] phase_reg   [NUM_VOICES];
    logic [PHASE_WIDTH-1:0] incr_reg    [NUM_VOICES];
    logic [SW-1:0]          shadow_reg  [NUM_VOICES];
    logic [7:0]             volume_reg  [NUM_VOICES];
    logic [1:0]             wave_reg    [NUM_VOICES];
    logic                   gate_reg    [NUM_VOICES];
    logic [7:0]             attack_reg  [NUM_VOICES];
    logic [7:0]             release_reg [NUM_VOICES];
    logic [7:0]             env_reg     [NUM_VOICES];

    logic                 enable_reg;
    logic [CW-1:0]        cnt_reg;
    logic signed [AW-1:0] acc_reg;
    logic signed [15:0]   samp_reg;
    logic signed [15:0]   w1_reg;
    logic [15:0]          lfsr_reg;
    logic [15:0]          sample_reg;
    logic                 valid_reg;
    logic                 overrun_reg;

    logic [2:0]           wr_field;
    logic [VA-1:0]        wr_voice;
    logic                 proc_active;
    logic                 load;
    logic [1:0]           step;
    logic [VA-1:0]        cur;
    logic [15:0]          u;
    logic [15:0]          tri_val;
    logic signed [15:0]   wave_next;
    logic [8:0]           env_sum;
    logic [7:0]           env_next;
    logic signed [24:0]   vol_prod;
    logic signed [24:0]   env_prod;
    logic signed [AW-1:0] term;
    logic [15:0]          sat_val;
    logic [15:0]          lfsr_next;
    logic                 unused_bits;

    assign wr_field    = wr_addr_in[VA+2:VA];
    assign wr_voice    = wr_addr_in[VA-1:0];
    assign proc_active = enable_reg && (cnt_reg < LOAD_CYCLE);
    assign load        = enable_reg && (cnt_reg == LOAD_CYCLE);
    assign step        = cnt_reg[1:0];
    assign cur         = cnt_reg[VA+1:2];
    assign u           = phase_reg[cur][PHASE_WIDTH-1 -: 16];

    always_comb begin
        tri_val = u[15] ? ~{u[14:0], 1'b0} : {u[14:0], 1'b0};
        case (wave_reg[cur])
            2'd0:    wave_next = u[15] ? 16'sh8001 : 16'sh7FFF;
            2'd1:    wave_next = u ^ 16'h8000;
            2'd2:    wave_next = tri_val ^ 16'h8000;
            default: wave_next = lfsr_reg;
        endcase
    end

    assign env_sum = {1'b0, env_reg[cur]} + {1'b0, attack_reg[cur]};
    always_comb begin
        env_next = 8'd0;
        if (gate_reg[cur])
            env_next = env_sum[8] ? 8'hFF : env_sum[7:0];
        else if (env_reg[cur] > release_reg[cur])
            env_next = env_reg[cur] - release_reg[cur];
    end

    // Unsigned 8-bit gains are widened with a zero MSB so the products stay signed.
    assign vol_prod = samp_reg * $signed({1'b0, volume_reg[cur]});
    assign env_prod = w1_reg * $signed({1'b0, env_reg[cur]});
    assign term     = {{VA{env_prod[23]}}, env_prod[23:8]};

    always_comb begin
        if ((&acc_reg[AW-1:15]) || !(|acc_reg[AW-1:15]))
            sat_val = acc_reg[15:0];
        else
            sat_val = acc_reg[AW-1] ? 16'h8000 : 16'h7FFF;
    end

    assign lfsr_next   = {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? 16'hB400 : 16'h0000);
    assign unused_bits = ^{vol_prod[24], vol_prod[7:0], env_prod[24], env_prod[7:0]};

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                phase_reg[i]   <= '0;
                incr_reg[i]    <= '0;
                shadow_reg[i]  <= '0;
                volume_reg[i]  <= '0;
                wave_reg[i]    <= '0;
                gate_reg[i]    <= 1'b0;
                attack_reg[i]  <= '0;
                release_reg[i] <= '0;
                env_reg[i]     <= '0;
            end
            enable_reg  <= 1'b0;
            cnt_reg     <= '0;
            acc_reg     <= '0;
            samp_reg    <= '0;
            w1_reg      <= '0;
            lfsr_reg    <= 16'hACE1;
            sample_reg  <= '0;
            valid_reg   <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            if (wr_en_in) begin
                case (wr_field)
                    3'd0: incr_reg[wr_voice]    <= {shadow_reg[wr_voice], wr_data_in};
                    3'd1: shadow_reg[wr_voice]  <= wr_data_in[SW-1:0];
                    3'd2: volume_reg[wr_voice]  <= wr_data_in[7:0];
                    3'd3: begin
                        wave_reg[wr_voice] <= wr_data_in[1:0];
                        gate_reg[wr_voice] <= wr_data_in[4];
                    end
                    3'd4: attack_reg[wr_voice]  <= wr_data_in[7:0];
                    3'd5: release_reg[wr_voice] <= wr_data_in[7:0];
                    3'd6: begin
                        enable_reg <= wr_data_in[0];
                        if (wr_data_in[1])
                            overrun_reg <= 1'b0;
                    end
                    default: ;
                endcase
            end

            if (!enable_reg || cnt_reg == LAST_CYCLE)
                cnt_reg <= '0;
            else
                cnt_reg <= cnt_reg + 1'b1;

            if (proc_active) begin
                case (step)
                    2'd0: begin
                        phase_reg[cur] <= phase_reg[cur] + incr_reg[cur];
                        if (cnt_reg == '0)
                            acc_reg <= '0;
                    end
                    2'd1: samp_reg <= wave_next;
                    2'd2: begin
                        env_reg[cur] <= env_next;
                        w1_reg       <= vol_prod[23:8];
                    end
                    default: acc_reg <= acc_reg + term;
                endcase
            end

            // A frame load outranks acceptance; an overrun is only a load onto an unaccepted sample.
            if (load) begin
                sample_reg <= sat_val;
                valid_reg  <= 1'b1;
                lfsr_reg   <= lfsr_next;
                if (valid_reg && !sample_ready_in)
                    overrun_reg <= 1'b1;
            end else if (valid_reg && sample_ready_in) begin
                valid_reg <= 1'b0;
            end
        end
    end

    assign sample_out       = sample_reg;
    assign sample_valid_out = valid_reg;
    assign overrun_out      = overrun_reg;
endmodule

// File: tb/tb_dds_voice_engine.sv
// Bench for dds_voice_engine: directed envelope/saturation/handshake steps plus
// randomized voice settings checked against a frame-level arithmetic model.
module tb_dds_voice_engine;
    localparam int NV = 4;
    localparam int PW = 20;
    localparam int FC = 1024;

    logic        clk_in = 1'b0;
    logic        reset_n_in = 1'b0;
    logic        wr_en_in = 1'b0;
    logic [4:0]  wr_addr_in = '0;
    logic [15:0] wr_data_in = '0;
    logic        sample_ready_in = 1'b1;
    logic [15:0] sample_out;
    logic        sample_valid_out;
    logic        overrun_out;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    int m_ph[NV], m_inc[NV], m_shd[NV], m_vol[NV], m_wav[NV];
    int m_gt[NV], m_att[NV], m_rel[NV], m_env[NV];
    int m_lfsr;
    int env_tab[8] = '{100, 200, 255, 255, 155, 55, 0, 0};

    dds_voice_engine #(.NUM_VOICES(NV), .PHASE_WIDTH(PW), .FRAME_CYCLES(FC)) dut (
        .clk_in(clk_in),
        .reset_n_in(reset_n_in),
        .wr_en_in(wr_en_in),
        .wr_addr_in(wr_addr_in),
        .wr_data_in(wr_data_in),
        .sample_out(sample_out),
        .sample_valid_out(sample_valid_out),
        .sample_ready_in(sample_ready_in),
        .overrun_out(overrun_out)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    function automatic int s16(input logic [15:0] x);
        return int'($signed(x));
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int v = 0; v < NV; v++) begin
            m_ph[v] = 0; m_inc[v] = 0; m_shd[v] = 0; m_vol[v] = 0; m_wav[v] = 0;
            m_gt[v] = 0; m_att[v] = 0; m_rel[v] = 0; m_env[v] = 0;
        end
        m_lfsr = 'hACE1;
    endfunction

    function automatic void model_write(input int f, input int v, input int d);
        case (f)
            0: m_inc[v] = m_shd[v] * 65536 + d;
            1: m_shd[v] = d % (1 << (PW - 16));
            2: m_vol[v] = d % 256;
            3: begin m_wav[v] = d % 4; m_gt[v] = (d / 16) % 2; end
            4: m_att[v] = d % 256;
            5: m_rel[v] = d % 256;
            default: ;
        endcase
    endfunction

    // One whole frame computed voice by voice with ordinary integer arithmetic.
    function automatic int model_frame();
        int acc = 0;
        int u, w, t, w1;
        for (int v = 0; v < NV; v++) begin
            m_ph[v] = (m_ph[v] + m_inc[v]) % (1 << PW);
            u = m_ph[v] / (1 << (PW - 16));
            case (m_wav[v])
                0: w = (u >= 32768) ? -32767 : 32767;
                1: w = u - 32768;
                2: begin
                    t = (u < 32768) ? 2 * u : 65535 - 2 * (u - 32768);
                    w = t - 32768;
                end
                default: w = (m_lfsr >= 32768) ? m_lfsr - 65536 : m_lfsr;
            endcase
            if (m_gt[v] != 0)
                m_env[v] = (m_env[v] + m_att[v] > 255) ? 255 : m_env[v] + m_att[v];
            else
                m_env[v] = (m_env[v] < m_rel[v]) ? 0 : m_env[v] - m_rel[v];
            w1 = (w * m_vol[v]) >>> 8;
            acc += (w1 * m_env[v]) >>> 8;
        end
        m_lfsr = (m_lfsr % 2 == 1) ? ((m_lfsr / 2) ^ 'hB400) : (m_lfsr / 2);
        if (acc > 32767) acc = 32767;
        else if (acc < -32768) acc = -32768;
        return acc;
    endfunction

    task automatic wr(input int f, input int v, input int d);
        @(negedge clk_in);
        wr_en_in   = 1'b1;
        wr_addr_in = 5'(f * 4 + v);
        wr_data_in = 16'(d);
        @(posedge clk_in);
        #1;
        wr_en_in = 1'b0;
        model_write(f, v, d);
    endtask

    task automatic wait_load(input string tag);
        int ok = 0;
        for (int k = 0; k < 2 * FC && ok == 0; k++) begin
            @(posedge clk_in);
            #1;
            if (sample_valid_out) ok = 1;
        end
        check({tag, "_timeout"}, ok, 1);
    endtask

    task automatic wait_to(input int target);
        while (cyc < target) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic frame_vs_model(input string tag);
        int e;
        wait_load(tag);
        e = model_frame();
        check(tag, s16(sample_out), e);
    endtask

    task automatic frame_vs_const(input string tag, input int c);
        int e;
        wait_load(tag);
        e = model_frame();
        check(tag, s16(sample_out), c);
    endtask

    task automatic idle_window(input int n, input string tag);
        int seen = 0;
        repeat (n) begin
            @(posedge clk_in);
            #1;
            if (sample_valid_out) seen++;
        end
        check(tag, seen, 0);
    endtask

    task automatic latency(input string tag);
        int k = 0;
        while (k < 2 * FC && !sample_valid_out) begin
            @(posedge clk_in);
            #1;
            k++;
        end
        check(tag, k, 4 * NV + 1);
    endtask

    task automatic rand_voice(input int v);
        wr(1, v, $urandom_range(0, 15));
        wr(0, v, $urandom_range(0, 65535));
        wr(2, v, $urandom_range(0, 255));
        wr(3, v, ($urandom_range(0, 3) != 0 ? 16 : 0) + $urandom_range(0, 3));
        wr(4, v, $urandom_range(0, 255));
        wr(5, v, $urandom_range(0, 255));
    endtask

    initial begin
        int e, lc, a_val, w1sq;
        w1sq = (32767 * 255) >>> 8;
        model_reset();

        #12;
        check("rst_sample", int'(sample_out), 0);
        check("rst_valid", int'(sample_valid_out), 0);
        check("rst_overrun", int'(overrun_out), 0);
        @(negedge clk_in);
        reset_n_in = 1'b1;
        idle_window(3000, "idle_disabled");

        // Envelope: one square voice at phase 0, attack then release by 100.
        wr(3, 0, 16'h10); wr(2, 0, 255); wr(4, 0, 100); wr(5, 0, 100);
        wr(6, 0, 1);
        latency("latency_enable");
        e = model_frame();
        check("env_f0", s16(sample_out), (w1sq * env_tab[0]) >>> 8);
        for (int i = 1; i < 4; i++)
            frame_vs_const($sformatf("env_f%0d", i), (w1sq * env_tab[i]) >>> 8);
        wr(3, 0, 16'h00);
        for (int i = 4; i < 8; i++)
            frame_vs_const($sformatf("env_f%0d", i), (w1sq * env_tab[i]) >>> 8);

        // Saturation with all four square voices at full scale.
        for (int v = 0; v < NV; v++) begin
            wr(3, v, 16'h10); wr(2, v, 255); wr(4, v, 255);
        end
        frame_vs_const("sat_pos", 32767);
        for (int v = 0; v < NV; v++) begin
            wr(1, v, 8); wr(0, v, 0);
        end
        frame_vs_const("sat_neg", -32768);
        for (int v = 0; v < NV; v++) begin
            wr(1, v, 0); wr(0, v, 0);
        end
        frame_vs_const("sat_neg_hold", -32768);

        // Increment atomicity on a saw voice parked at phase 0x80000.
        for (int v = 1; v < NV; v++) wr(2, v, 0);
        wr(3, 0, 16'h11);
        wr(1, 0, 16'h000A);
        frame_vs_const("atom_shadow_only", 0);
        wr(0, 0, 16'h0000);
        frame_vs_const("atom_commit", -24385);
        frame_vs_model("atom_next");

        // Randomized voice settings.
        for (int v = 0; v < NV; v++) rand_voice(v);
        for (int f = 0; f < 6; f++) begin
            frame_vs_model($sformatf("rand_f%0d", f));
            rand_voice($urandom_range(0, NV - 1));
        end
        frame_vs_model("rand_last");

        // Disable between frames, then re-enable.
        wr(6, 0, 0);
        idle_window(1500, "idle_after_disable");
        wr(6, 0, 1);
        latency("latency_reenable");
        e = model_frame();
        check("reenable_sample", s16(sample_out), e);

        // Handshake and overrun.
        wait_load("pre_ovr");
        e = model_frame();
        check("pre_ovr", s16(sample_out), e);
        lc = cyc;
        @(posedge clk_in);
        #1;
        sample_ready_in = 1'b0;
        wait_to(lc + FC);
        e = model_frame();
        a_val = e;
        check("ovr_load1_sample", s16(sample_out), e);
        check("ovr_load1_valid", int'(sample_valid_out), 1);
        check("ovr_load1_flag", int'(overrun_out), 0);
        wait_to(lc + 2 * FC - 1);
        check("ovr_hold_sample", s16(sample_out), a_val);
        check("ovr_hold_flag", int'(overrun_out), 0);
        wait_to(lc + 2 * FC);
        e = model_frame();
        check("ovr_load2_sample", s16(sample_out), e);
        check("ovr_load2_flag", int'(overrun_out), 1);
        check("ovr_load2_valid", int'(sample_valid_out), 1);
        wr(6, 0, 3);
        check("ovr_cleared", int'(overrun_out), 0);
        check("ovr_clear_valid", int'(sample_valid_out), 1);
        wait_to(lc + 3 * FC - 1);
        sample_ready_in = 1'b1;
        wait_to(lc + 3 * FC);
        e = model_frame();
        check("accept_at_load_sample", s16(sample_out), e);
        check("accept_at_load_valid", int'(sample_valid_out), 1);
        check("accept_at_load_flag", int'(overrun_out), 0);
        @(posedge clk_in);
        #1;
        check("accept_drops_valid", int'(sample_valid_out), 0);

        // Asynchronous reset while a sample is pending.
        sample_ready_in = 1'b0;
        frame_vs_model("pre_reset");
        check("pre_reset_valid", int'(sample_valid_out), 1);
        #3;
        reset_n_in = 1'b0;
        #1;
        check("async_rst_sample", int'(sample_out), 0);
        check("async_rst_valid", int'(sample_valid_out), 0);
        check("async_rst_overrun", int'(overrun_out), 0);
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        reset_n_in = 1'b1;
        model_reset();
        sample_ready_in = 1'b1;
        idle_window(3000, "idle_after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
